// File: rtl/hazard_forward_ctrl.sv
// Hazard controller for the 5-stage LEGv8 pipeline.
// Tracks ID/EX, EX/MEM and MEM/WB destinations to drive the EX operand forwarding selects, load-use stalls and branch flushes.
module hazard_forward_ctrl #(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned ZERO_REG   = 31,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  CLOCK,
   input  logic                  RESET_N,
   input  logic [REG_ADDR_W-1:0] id_rn,
   input  logic [REG_ADDR_W-1:0] id_rm,
   input  logic                  id_uses_rn,
   input  logic                  id_uses_rm,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_RegWrite,
   input  logic                  id_MemRead,
   input  logic                  branch_taken,
   output logic [1:0]            ForwardA,
   output logic [1:0]            ForwardB,
   output logic                  PCWrite,
   output logic                  IFIDWrite,
   output logic                  bubble,
   output logic [CNT_W-1:0]      stall_count
);

   localparam logic [REG_ADDR_W-1:0] XZR     = REG_ADDR_W'(ZERO_REG);
   localparam logic [CNT_W-1:0]      CNT_MAX = '1;

   logic [REG_ADDR_W-1:0] idex_rn_q, idex_rn_d;
   logic [REG_ADDR_W-1:0] idex_rm_q, idex_rm_d;
   logic                  idex_uses_rn_q, idex_uses_rn_d;
   logic                  idex_uses_rm_q, idex_uses_rm_d;
   logic [REG_ADDR_W-1:0] idex_rd_q, idex_rd_d;
   logic                  idex_regwrite_q, idex_regwrite_d;
   logic                  idex_memread_q, idex_memread_d;
   logic [REG_ADDR_W-1:0] exmem_rd_q, exmem_rd_d;
   logic                  exmem_regwrite_q, exmem_regwrite_d;
   logic [REG_ADDR_W-1:0] memwb_rd_q, memwb_rd_d;
   logic                  memwb_regwrite_q, memwb_regwrite_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic load_use;
   logic stall;
   logic flush;

   // Newest writer wins; XZR and bubbles (RegWrite=0) never match.
   function automatic logic [1:0] fwd_sel(
      input logic                  uses,
      input logic [REG_ADDR_W-1:0] src,
      input logic                  exm_we,
      input logic [REG_ADDR_W-1:0] exm_rd,
      input logic                  mwb_we,
      input logic [REG_ADDR_W-1:0] mwb_rd
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (uses && exm_we && (exm_rd != XZR) && (exm_rd == src)) begin
         sel = 2'b10;
      end else if (uses && mwb_we && (mwb_rd != XZR) && (mwb_rd == src)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   // Load-use detection and stall/flush arbitration; outputs are forced benign while in reset.
   always_comb begin
      load_use = 1'b0;
      if (idex_memread_q && (idex_rd_q != XZR)) begin
         load_use = (id_uses_rn && (id_rn == idex_rd_q)) ||
                    (id_uses_rm && (id_rm == idex_rd_q));
      end
      stall     = load_use && !branch_taken && RESET_N;
      flush     = branch_taken && RESET_N;
      PCWrite   = !stall;
      IFIDWrite = !stall;
      bubble    = stall || flush;
   end

   always_comb begin
      ForwardA = fwd_sel(idex_uses_rn_q, idex_rn_q, exmem_regwrite_q, exmem_rd_q,
                         memwb_regwrite_q, memwb_rd_q);
      ForwardB = fwd_sel(idex_uses_rm_q, idex_rm_q, exmem_regwrite_q, exmem_rd_q,
                         memwb_regwrite_q, memwb_rd_q);
   end

   // Shadow pipeline advance and saturating stall counter.
   always_comb begin
      idex_rn_d        = id_rn;
      idex_rm_d        = id_rm;
      idex_uses_rn_d   = id_uses_rn;
      idex_uses_rm_d   = id_uses_rm;
      idex_rd_d        = id_rd;
      idex_regwrite_d  = id_RegWrite;
      idex_memread_d   = id_MemRead;
      exmem_rd_d       = idex_rd_q;
      exmem_regwrite_d = idex_regwrite_q;
      memwb_rd_d       = exmem_rd_q;
      memwb_regwrite_d = exmem_regwrite_q;
      cnt_d            = cnt_q;
      if (bubble) begin
         idex_rn_d       = '0;
         idex_rm_d       = '0;
         idex_uses_rn_d  = 1'b0;
         idex_uses_rm_d  = 1'b0;
         idex_rd_d       = '0;
         idex_regwrite_d = 1'b0;
         idex_memread_d  = 1'b0;
      end
      if (stall && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         idex_rn_q        <= '0;
         idex_rm_q        <= '0;
         idex_uses_rn_q   <= 1'b0;
         idex_uses_rm_q   <= 1'b0;
         idex_rd_q        <= '0;
         idex_regwrite_q  <= 1'b0;
         idex_memread_q   <= 1'b0;
         exmem_rd_q       <= '0;
         exmem_regwrite_q <= 1'b0;
         memwb_rd_q       <= '0;
         memwb_regwrite_q <= 1'b0;
         cnt_q            <= '0;
      end else begin
         idex_rn_q        <= idex_rn_d;
         idex_rm_q        <= idex_rm_d;
         idex_uses_rn_q   <= idex_uses_rn_d;
         idex_uses_rm_q   <= idex_uses_rm_d;
         idex_rd_q        <= idex_rd_d;
         idex_regwrite_q  <= idex_regwrite_d;
         idex_memread_q   <= idex_memread_d;
         exmem_rd_q       <= exmem_rd_d;
         exmem_regwrite_q <= exmem_regwrite_d;
         memwb_rd_q       <= memwb_rd_d;
         memwb_regwrite_q <= memwb_regwrite_d;
         cnt_q            <= cnt_d;
      end
   end

   assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl with a pipeline reference model and an expectation queue.
module tb_hazard_forward_ctrl;

   localparam int unsigned AW    = 5;
   localparam int unsigned ZR    = 31;
   localparam int unsigned CNT_W = 4;

   logic            CLOCK = 1'b0;
   logic            RESET_N;
   logic [AW-1:0]   id_rn, id_rm, id_rd;
   logic            id_uses_rn, id_uses_rm, id_RegWrite, id_MemRead, branch_taken;
   logic [1:0]      ForwardA, ForwardB;
   logic            PCWrite, IFIDWrite, bubble;
   logic [CNT_W-1:0] stall_count;

   always #5 CLOCK = ~CLOCK;

   hazard_forward_ctrl #(.REG_ADDR_W(AW), .ZERO_REG(ZR), .CNT_W(CNT_W)) dut (
      .CLOCK(CLOCK), .RESET_N(RESET_N),
      .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
      .id_rd(id_rd), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
      .branch_taken(branch_taken),
      .ForwardA(ForwardA), .ForwardB(ForwardB), .PCWrite(PCWrite),
      .IFIDWrite(IFIDWrite), .bubble(bubble), .stall_count(stall_count)
   );

   typedef struct packed {
      logic [AW-1:0] rn;
      logic [AW-1:0] rm;
      logic          urn;
      logic          urm;
      logic [AW-1:0] rd;
      logic          rw;
      logic          mr;
      logic          bt;
   } stim_t;

   typedef struct packed {
      logic [1:0]       fa;
      logic [1:0]       fb;
      logic             pcw;
      logic             ifw;
      logic             bub;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t sb_q[$];

   // Reference pipeline: one slot per stage.
   stim_t            m_idex;
   logic [AW-1:0]    m_exm_rd, m_mwb_rd;
   logic             m_exm_rw, m_mwb_rw;
   logic [CNT_W-1:0] m_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic stim_t mk(input int rn, input int rm, input bit urn, input bit urm,
                                input int rd, input bit rw, input bit mr, input bit bt);
      stim_t s;
      s.rn = AW'(rn); s.rm = AW'(rm); s.urn = urn; s.urm = urm;
      s.rd = AW'(rd); s.rw = rw; s.mr = mr; s.bt = bt;
      return s;
   endfunction

   function automatic logic [1:0] m_fwd(input logic u, input logic [AW-1:0] src);
      if (!u) return 2'b00;
      if (m_exm_rw && (m_exm_rd != AW'(ZR)) && (m_exm_rd == src)) return 2'b10;
      if (m_mwb_rw && (m_mwb_rd != AW'(ZR)) && (m_mwb_rd == src)) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic m_stall(input stim_t s);
      logic hz;
      hz = m_idex.mr && (m_idex.rd != AW'(ZR)) &&
           ((s.urn && (s.rn == m_idex.rd)) || (s.urm && (s.rm == m_idex.rd)));
      return hz && !s.bt;
   endfunction

   task automatic drive(input stim_t s);
      id_rn = s.rn; id_rm = s.rm; id_uses_rn = s.urn; id_uses_rm = s.urm;
      id_rd = s.rd; id_RegWrite = s.rw; id_MemRead = s.mr; branch_taken = s.bt;
   endtask

   task automatic model_reset();
      m_idex = '0; m_exm_rd = '0; m_exm_rw = 1'b0;
      m_mwb_rd = '0; m_mwb_rw = 1'b0; m_cnt = '0;
   endtask

   // Drive at negedge, queue the model's expectation, then compare mid-cycle.
   task automatic apply(input stim_t s);
      exp_t e, got;
      logic st;
      @(negedge CLOCK);
      drive(s);
      st    = m_stall(s);
      e.fa  = m_fwd(m_idex.urn, m_idex.rn);
      e.fb  = m_fwd(m_idex.urm, m_idex.rm);
      e.pcw = !st;
      e.ifw = !st;
      e.bub = st || s.bt;
      e.cnt = m_cnt;
      sb_q.push_back(e);
      #2;
      got = sb_q.pop_front();
      chk("ForwardA", 32'(ForwardA), 32'(got.fa));
      chk("ForwardB", 32'(ForwardB), 32'(got.fb));
      chk("PCWrite", 32'(PCWrite), 32'(got.pcw));
      chk("IFIDWrite", 32'(IFIDWrite), 32'(got.ifw));
      chk("bubble", 32'(bubble), 32'(got.bub));
      chk("stall_count", 32'(stall_count), 32'(got.cnt));
   endtask

   task automatic advance(input stim_t s);
      logic st;
      st = m_stall(s);
      @(posedge CLOCK);
      m_mwb_rd = m_exm_rd;
      m_mwb_rw = m_exm_rw;
      m_exm_rd = m_idex.rd;
      m_exm_rw = m_idex.rw;
      m_idex   = (st || s.bt) ? '0 : s;
      if (st && (m_cnt != '1)) m_cnt = m_cnt + CNT_W'(1);
   endtask

   task automatic step(input stim_t s);
      apply(s);
      advance(s);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_t nop, s;
      logic [31:0] r;
      nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      RESET_N = 1'b0;
      drive(nop);

      // Reset held with random inputs.
      for (int i = 0; i < 4; i++) begin
         @(negedge CLOCK);
         r = $urandom;
         s = r[$bits(stim_t)-1:0];
         s.bt = i[0];
         s.mr = 1'b1;
         drive(s);
         #2;
         chk("rst_ForwardA", 32'(ForwardA), 32'd0);
         chk("rst_ForwardB", 32'(ForwardB), 32'd0);
         chk("rst_PCWrite", 32'(PCWrite), 32'd1);
         chk("rst_IFIDWrite", 32'(IFIDWrite), 32'd1);
         chk("rst_bubble", 32'(bubble), 32'd0);
         chk("rst_stall_count", 32'(stall_count), 32'd0);
      end
      @(negedge CLOCK);
      drive(nop);
      RESET_N = 1'b1;

      // EX/MEM then MEM/WB forwarding of X3.
      step(mk(0, 0, 0, 0, 3, 1, 0, 0));
      step(mk(3, 1, 1, 0, 4, 1, 0, 0));
      apply(mk(3, 0, 1, 0, 0, 0, 0, 0));
      chk("exmem_fwdA", 32'(ForwardA), 32'b10);
      advance(mk(3, 0, 1, 0, 0, 0, 0, 0));
      apply(nop);
      chk("memwb_fwdA", 32'(ForwardA), 32'b01);
      advance(nop);

      // Two writers of X5: newest wins.
      step(mk(0, 0, 0, 0, 5, 1, 0, 0));
      step(mk(0, 0, 0, 0, 5, 1, 0, 0));
      step(mk(5, 5, 1, 1, 10, 1, 0, 0));
      apply(nop);
      chk("double_fwdA", 32'(ForwardA), 32'b10);
      chk("double_fwdB", 32'(ForwardB), 32'b10);
      advance(nop);

      // XZR never forwards or stalls.
      step(mk(0, 0, 0, 0, 31, 1, 0, 0));
      step(mk(31, 0, 1, 0, 0, 0, 0, 0));
      apply(nop);
      chk("xzr_fwdA", 32'(ForwardA), 32'b00);
      advance(nop);
      step(mk(0, 0, 0, 0, 31, 1, 1, 0));
      apply(mk(31, 0, 1, 0, 0, 0, 0, 0));
      chk("xzr_load_bubble", 32'(bubble), 32'd0);
      chk("xzr_load_pcwrite", 32'(PCWrite), 32'd1);
      advance(mk(31, 0, 1, 0, 0, 0, 0, 0));

      // Load-use on X2 through Rm.
      step(mk(0, 0, 0, 0, 2, 1, 1, 0));
      apply(mk(0, 2, 0, 1, 6, 1, 0, 0));
      chk("lu_pcwrite", 32'(PCWrite), 32'd0);
      chk("lu_ifidwrite", 32'(IFIDWrite), 32'd0);
      chk("lu_bubble", 32'(bubble), 32'd1);
      advance(mk(0, 2, 0, 1, 6, 1, 0, 0));
      apply(mk(0, 2, 0, 1, 6, 1, 0, 0));
      chk("lu_clear_bubble", 32'(bubble), 32'd0);
      chk("lu_count", 32'(stall_count), 32'd1);
      advance(mk(0, 2, 0, 1, 6, 1, 0, 0));
      apply(nop);
      chk("lu_fwdB", 32'(ForwardB), 32'b01);
      advance(nop);

      // Branch flush overrides a load-use stall.
      step(mk(0, 0, 0, 0, 7, 1, 1, 0));
      apply(mk(7, 0, 1, 0, 0, 0, 0, 1));
      chk("flush_bubble", 32'(bubble), 32'd1);
      chk("flush_pcwrite", 32'(PCWrite), 32'd1);
      advance(mk(7, 0, 1, 0, 0, 0, 0, 1));
      apply(nop);
      chk("flush_count", 32'(stall_count), 32'd1);
      advance(nop);

      // Drive 2^CNT_W+3 stalls; counter saturates.
      for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
         step(mk(0, 0, 0, 0, 9, 1, 1, 0));
         step(mk(9, 0, 1, 0, 0, 0, 0, 0));
      end
      apply(nop);
      chk("sat_count", 32'(stall_count), 32'd15);
      advance(nop);

      // Reset asserted in the middle of a stall.
      step(mk(0, 0, 0, 0, 8, 1, 1, 0));
      apply(mk(8, 0, 1, 0, 0, 0, 0, 0));
      chk("midrst_pre_pcwrite", 32'(PCWrite), 32'd0);
      #1 RESET_N = 1'b0;
      #1;
      chk("midrst_pcwrite", 32'(PCWrite), 32'd1);
      chk("midrst_ifidwrite", 32'(IFIDWrite), 32'd1);
      chk("midrst_bubble", 32'(bubble), 32'd0);
      chk("midrst_count", 32'(stall_count), 32'd0);
      model_reset();
      @(negedge CLOCK);
      drive(nop);
      RESET_N = 1'b1;
      step(mk(8, 0, 1, 0, 0, 0, 0, 0));
      step(nop);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
